// File: rtl/qspi_arb_pkg.sv
// qspi_arb_pkg: shared encodings for the QSPI bus arbiter.
// Chip-select, FSM, owner, size codes and address-decode helpers.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_FLASH = 2'd1,
    SEL_RAM_A = 2'd2,
    SEL_RAM_B = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ACTIVE,
    ST_GAP
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DATA
  } owner_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  localparam int RAM_B_BIT = 23;
  localparam int DEV_BIT   = 24;

  function automatic sel_e dec_sel(
    input logic [24:0] a
  );
    sel_e s;
    s = SEL_FLASH;
    unique case (1'b1)
      !a[DEV_BIT]:                 s = SEL_FLASH;
      a[DEV_BIT] && !a[RAM_B_BIT]: s = SEL_RAM_A;
      a[DEV_BIT] && a[RAM_B_BIT]:  s = SEL_RAM_B;
      default:                     s = SEL_FLASH;
    endcase
    return s;
  endfunction

  // RAM devices are 8 MiB, so their local address drops the bank bit.
  function automatic logic [23:0] dev_addr(
    input logic [24:0] a
  );
    logic [23:0] r;
    if (!a[DEV_BIT]) r = a[23:0];
    else             r = {1'b0, a[22:0]};
    return r;
  endfunction

endpackage

// File: rtl/qspi_bus_arbiter_pick.sv
// qspi_arb_pick: instr/data priority pick with starvation counter.
// Ports: clk, rst, en, instr_req, data_req -> grant_instr, grant_data.
module qspi_arb_pick #(
  parameter int MAX_DATA_WINS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic instr_req,
  input  logic data_req,
  output logic grant_instr,
  output logic grant_data
);

  localparam int CW = $clog2(MAX_DATA_WINS + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_DATA_WINS);

  logic [CW-1:0] win_cnt;
  logic          force_i;

  always_comb begin
    force_i     = instr_req && (win_cnt == WMAX);
    grant_data  = en && data_req && !force_i;
    grant_instr = en && instr_req && !grant_data;
  end

  // Counts data wins only while a fetch is actually waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
    end else if (!instr_req || grant_instr) begin
      win_cnt <= '0;
    end else if (grant_data && win_cnt != WMAX) begin
      win_cnt <= win_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// qspi_bus_arbiter: shares qspi_ctrl between fetch and data ports.
// Ports: instr_* / data_* CPU side, ctrl_* controller side, rdata.
// Option: QSPI_ARB_TIMEOUT_EN adds an ACTIVE watchdog (ctrl_abort).
module qspi_bus_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int MAX_DATA_WINS  = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req,
  input  logic [23:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  output logic        instr_done,
  input  logic        data_req,
  input  logic [24:0] data_addr,
  input  logic        data_we,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic        data_done,
  output logic        data_err,
  output logic [31:0] rdata,
  output logic        ctrl_start,
  output logic [1:0]  ctrl_sel,
  output logic [23:0] ctrl_addr,
  output logic        ctrl_we,
  output logic [1:0]  ctrl_size,
  output logic [31:0] ctrl_wdata,
  input  logic        ctrl_rvalid,
  input  logic [31:0] ctrl_rdata,
  input  logic        ctrl_done,
  output logic        ctrl_abort
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  owner_e      owner_q;
  sel_e        sel_q;
  logic [3:0]  gap_q;
  logic [23:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;

  logic grant_instr, grant_data;
  logic flash_wr, issue, act, fin, abort;

  qspi_arb_pick #(
    .MAX_DATA_WINS(MAX_DATA_WINS)
  ) u_pick (
    .clk        (clk),
    .rst        (rst),
    .en         (state_q == ST_IDLE && !rst),
    .instr_req  (instr_req),
    .data_req   (data_req),
    .grant_instr(grant_instr),
    .grant_data (grant_data)
  );

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0] to_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != ST_ACTIVE) to_q <= '0;
    else                             to_q <= to_q + 10'd1;
  end

  // A done in the same cycle wins over the watchdog.
  assign abort = (state_q == ST_ACTIVE) &&
                 (to_q == TO_LAST) && !ctrl_done;
`else
  assign abort = 1'b0;
`endif

  assign ctrl_abort = abort;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    // Flash write is rejected at grant time and never issued.
    flash_wr = grant_data && data_we && !data_addr[DEV_BIT];
    unique case (state_q)
      ST_IDLE: begin
        if (grant_instr || (grant_data && !flash_wr)) begin
          state_d = ST_ISSUE;
          issue   = 1'b1;
        end
      end
      ST_ISSUE:  state_d = ST_ACTIVE;
      ST_ACTIVE: if (ctrl_done || abort) state_d = ST_GAP;
      ST_GAP:    if (gap_q == GAP_LAST) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    act          = (state_q == ST_ACTIVE);
    fin          = act && (ctrl_done || abort);
    instr_gnt    = grant_instr;
    data_gnt     = grant_data;
    instr_rvalid = act && owner_q == OWN_INSTR && ctrl_rvalid;
    data_rvalid  = act && owner_q == OWN_DATA && ctrl_rvalid;
    instr_done   = fin && owner_q == OWN_INSTR;
    data_done    = fin && owner_q == OWN_DATA;
    data_err     = flash_wr || (abort && owner_q == OWN_DATA);
    ctrl_start   = (state_q == ST_ISSUE);
    ctrl_sel     = sel_q;
    ctrl_addr    = addr_q;
    ctrl_we      = we_q;
    ctrl_size    = size_q;
    ctrl_wdata   = wdata_q;
    rdata        = ctrl_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      owner_q <= OWN_NONE;
      sel_q   <= SEL_NONE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= (state_q == ST_GAP) ? gap_q + 4'd1 : 4'd0;
      if (issue && grant_instr) begin
        owner_q <= OWN_INSTR;
        sel_q   <= SEL_FLASH;
        addr_q  <= instr_addr;
        we_q    <= 1'b0;
        size_q  <= SZ_WORD;
        wdata_q <= '0;
      end else if (issue) begin
        owner_q <= OWN_DATA;
        sel_q   <= dec_sel(data_addr);
        addr_q  <= dev_addr(data_addr);
        we_q    <= data_we;
        size_q  <= data_size;
        wdata_q <= data_wdata;
      end else if (fin) begin
        owner_q <= OWN_NONE;
        sel_q   <= SEL_NONE;
        we_q    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// tb_qspi_bus_arbiter: randomized self-checking bench for the arbiter.
// Acts as CPU and as qspi_ctrl; QSPI_ARB_TIMEOUT_EN adds watchdog test.
module tb_qspi_bus_arbiter;

  localparam int GAP  = 2;
  localparam int MAXW = 4;
  localparam int TO   = 1023;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [23:0] instr_addr;
  logic        instr_gnt, instr_rvalid, instr_done;
  logic        data_req;
  logic [24:0] data_addr;
  logic        data_we;
  logic [1:0]  data_size;
  logic [31:0] data_wdata;
  logic        data_gnt, data_rvalid, data_done, data_err;
  logic [31:0] rdata;
  logic        ctrl_start;
  logic [1:0]  ctrl_sel;
  logic [23:0] ctrl_addr;
  logic        ctrl_we;
  logic [1:0]  ctrl_size;
  logic [31:0] ctrl_wdata;
  logic        ctrl_rvalid;
  logic [31:0] ctrl_rdata;
  logic        ctrl_done;
  logic        ctrl_abort;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qspi_bus_arbiter #(
    .GAP_CYCLES(GAP),
    .MAX_DATA_WINS(MAXW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_gnt(instr_gnt), .instr_rvalid(instr_rvalid),
    .instr_done(instr_done),
    .data_req(data_req), .data_addr(data_addr),
    .data_we(data_we), .data_size(data_size),
    .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_done(data_done),
    .data_err(data_err), .rdata(rdata),
    .ctrl_start(ctrl_start), .ctrl_sel(ctrl_sel),
    .ctrl_addr(ctrl_addr), .ctrl_we(ctrl_we),
    .ctrl_size(ctrl_size), .ctrl_wdata(ctrl_wdata),
    .ctrl_rvalid(ctrl_rvalid), .ctrl_rdata(ctrl_rdata),
    .ctrl_done(ctrl_done), .ctrl_abort(ctrl_abort)
  );

  // Bench-side protocol guard: a request must stay up until granted.
  logic ip = 1'b0, dp = 1'b0;
  always @(posedge clk) begin
    if (!rst && ip && !instr_req)
      $error("instr_req dropped before instr_gnt");
    if (!rst && dp && !data_req)
      $error("data_req dropped before data_gnt");
    ip <= instr_req && !instr_gnt && !rst;
    dp <= data_req && !data_gnt && !rst;
  end

  function automatic logic [101:0] all_outs();
    return {instr_gnt, instr_rvalid, instr_done, data_gnt,
            data_rvalid, data_done, data_err, rdata, ctrl_start,
            ctrl_sel, ctrl_addr, ctrl_we, ctrl_size, ctrl_wdata,
            ctrl_abort};
  endfunction

  // Reference decode from the address map, by plain arithmetic.
  function automatic logic [1:0] m_sel(input int unsigned a);
    int unsigned dev = a / (1 << 23);
    if (dev < 2) return 2'd1;
    return (dev == 2) ? 2'd2 : 2'd3;
  endfunction

  function automatic logic [23:0] m_addr(input int unsigned a);
    int unsigned dev = a / (1 << 23);
    if (dev < 2) return 24'(a % (1 << 24));
    return 24'(a % (1 << 23));
  endfunction

  task automatic wait_any_gnt(output int k, output bit gi,
                              output bit gd);
    k = 0;
    while (!(instr_gnt || data_gnt) && k < 64) begin
      @(negedge clk); #1;
      k++;
    end
    gi = instr_gnt;
    gd = data_gnt;
  endtask

  // Plays qspi_ctrl from the ISSUE cycle; exits sampled in GAP cycle 1.
  task automatic run_ctrl(input int lat, input logic [31:0] rd,
                          input bit give_rv,
                          output bit irv, output bit drv,
                          output bit idn, output bit ddn,
                          output logic [31:0] rseen);
    irv = 0; drv = 0; idn = 0; ddn = 0; rseen = '0;
    repeat (lat) begin @(negedge clk); #1; end
    if (give_rv) begin
      @(negedge clk);
      ctrl_rvalid = 1'b1; ctrl_rdata = rd;
      #1;
      irv = instr_rvalid; drv = data_rvalid; rseen = rdata;
    end
    @(negedge clk);
    ctrl_rvalid = 1'b0; ctrl_done = 1'b1;
    #1;
    idn = instr_done; ddn = data_done;
    @(negedge clk);
    ctrl_done = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [101:0] v;
    rst = 1'b1;
    instr_req = 0; instr_addr = '0;
    data_req = 0; data_addr = '0; data_we = 0;
    data_size = '0; data_wdata = '0;
    ctrl_rvalid = 1'b1; ctrl_rdata = '0; ctrl_done = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    v = all_outs();
    n_chk++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0", v);
    end
    @(negedge clk);
    rst = 1'b0; ctrl_rvalid = 1'b0; ctrl_done = 1'b0;
    #1;
  endtask

  task automatic test_instr_only();
    bit irv, drv, idn, ddn;
    logic [31:0] rs;
    @(negedge clk);
    instr_req = 1; instr_addr = 24'h000100;
    #1;
    n_chk++;
    if ({instr_gnt, data_gnt, ctrl_start} !== 3'b100) begin
      n_fail++;
      $display("FAIL io_gnt: got %b want 100",
               {instr_gnt, data_gnt, ctrl_start});
    end
    @(negedge clk);
    instr_req = 0;
    #1;
    n_chk++;
    if ({ctrl_start, ctrl_sel, ctrl_addr, ctrl_we} !==
        {1'b1, 2'd1, 24'h000100, 1'b0}) begin
      n_fail++;
      $display("FAIL io_issue: got %b %0d %h want 1 1 000100",
               ctrl_start, ctrl_sel, ctrl_addr);
    end
    @(negedge clk);
    ctrl_rvalid = 1; ctrl_rdata = 32'hDEADBEEF;
    #1;
    n_chk++;
    if ({ctrl_start, instr_rvalid, data_rvalid, rdata} !==
        {3'b010, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL io_rvalid: got %b%b%b %h want 010 deadbeef",
               ctrl_start, instr_rvalid, data_rvalid, rdata);
    end
    @(negedge clk);
    ctrl_rvalid = 0; ctrl_done = 1;
    #1;
    n_chk++;
    if ({instr_done, data_done, ctrl_sel} !== 4'b1001) begin
      n_fail++;
      $display("FAIL io_done: got %b want 1001",
               {instr_done, data_done, ctrl_sel});
    end
    for (int g = 1; g <= GAP; g++) begin
      @(negedge clk);
      ctrl_done = 0; instr_req = 1; instr_addr = 24'h000200;
      #1;
      n_chk++;
      if ({instr_gnt, ctrl_start, ctrl_sel} !== 4'b0000) begin
        n_fail++;
        $display("FAIL io_gap%0d: got %b want 0000", g,
                 {instr_gnt, ctrl_start, ctrl_sel});
      end
    end
    @(negedge clk); #1;
    n_chk++;
    if (instr_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL io_gap_end_gnt: got %b want 1", instr_gnt);
    end
    @(negedge clk);
    instr_req = 0;
    #1;
    n_chk++;
    if ({ctrl_start, ctrl_addr} !== {1'b1, 24'h000200}) begin
      n_fail++;
      $display("FAIL io_second: got %b %h want 1 000200",
               ctrl_start, ctrl_addr);
    end
    run_ctrl(1, 32'h0BADF00D, 1, irv, drv, idn, ddn, rs);
    n_chk++;
    if ({irv, drv, idn, ddn, rs} !== {4'b1010, 32'h0BADF00D}) begin
      n_fail++;
      $display("FAIL io_second_serve: got %b %h want 1010 0badf00d",
               {irv, drv, idn, ddn}, rs);
    end
  endtask

  task automatic test_simultaneous();
    int k;
    bit gi, gd, irv, drv, idn, ddn;
    logic [31:0] rs, rd;
    @(negedge clk);
    data_req = 1; data_addr = 25'h1800010; data_we = 0;
    data_size = 2; instr_req = 1; instr_addr = 24'h000000;
    #1;
    wait_any_gnt(k, gi, gd);
    n_chk++;
    if ({gi, gd} !== 2'b01 || k != GAP - 1) begin
      n_fail++;
      $display("FAIL sim_first: got %b k=%0d want 01 k=%0d",
               {gi, gd}, k, GAP - 1);
    end
    @(negedge clk);
    data_req = 0;
    #1;
    n_chk++;
    if ({ctrl_start, ctrl_sel, ctrl_addr} !==
        {1'b1, 2'd3, 24'h000010}) begin
      n_fail++;
      $display("FAIL sim_issue: got %b %0d %h want 1 3 000010",
               ctrl_start, ctrl_sel, ctrl_addr);
    end
    rd = $urandom;
    run_ctrl($urandom_range(0, 3), rd, 1, irv, drv, idn, ddn, rs);
    n_chk++;
    if ({irv, drv, idn, ddn, rs} !== {4'b0101, rd}) begin
      n_fail++;
      $display("FAIL sim_data_serve: got %b %h want 0101 %h",
               {irv, drv, idn, ddn}, rs, rd);
    end
    wait_any_gnt(k, gi, gd);
    n_chk++;
    if ({gi, gd} !== 2'b10 || k != GAP) begin
      n_fail++;
      $display("FAIL sim_second: got %b k=%0d want 10 k=%0d",
               {gi, gd}, k, GAP);
    end
    @(negedge clk);
    instr_req = 0;
    #1;
    n_chk++;
    if ({ctrl_start, ctrl_sel, ctrl_addr} !== {1'b1, 2'd1, 24'h0})
    begin
      n_fail++;
      $display("FAIL sim_instr_issue: got %b %0d %h want 1 1 0",
               ctrl_start, ctrl_sel, ctrl_addr);
    end
    run_ctrl(0, $urandom, 1, irv, drv, idn, ddn, rs);
  endtask

  task automatic test_starvation();
    int k, streak;
    bit gi, gd, exp_i, irv, drv, idn, ddn;
    logic [31:0] rs;
    streak = 0;
    @(negedge clk);
    instr_req = 1; instr_addr = 24'($urandom);
    data_req = 1; data_we = 0; data_size = 2;
    data_addr = {1'b1, 24'($urandom)};
    #1;
    for (int i = 0; i < 10; i++) begin
      wait_any_gnt(k, gi, gd);
      exp_i = (streak == MAXW);
      n_chk++;
      if (gi !== exp_i || gd !== !exp_i) begin
        n_fail++;
        $display("FAIL starve_%0d: got i=%b d=%b want i=%b d=%b",
                 i, gi, gd, exp_i, !exp_i);
      end
      streak = exp_i ? 0 : streak + 1;
      @(negedge clk);
      if (gi) begin
        if (i == 9) instr_req = 0;
        else instr_addr = 24'($urandom);
      end
      if (gd) data_addr = {1'b1, 24'($urandom)};
      #1;
      n_chk++;
      if (ctrl_start !== 1'b1) begin
        n_fail++;
        $display("FAIL starve_start_%0d: got %b want 1",
                 i, ctrl_start);
      end
      run_ctrl($urandom_range(0, 2), $urandom, 1,
               irv, drv, idn, ddn, rs);
    end
    for (int j = 0; j < 3 && (instr_req || data_req); j++) begin
      wait_any_gnt(k, gi, gd);
      @(negedge clk);
      if (gi) instr_req = 0;
      if (gd) data_req = 0;
      #1;
      run_ctrl(0, $urandom, 1, irv, drv, idn, ddn, rs);
    end
  endtask

  task automatic test_write_ram();
    int k;
    bit gi, gd, irv, drv, idn, ddn;
    logic [31:0] rs;
    @(negedge clk);
    data_req = 1; data_addr = 25'h1000004; data_we = 1;
    data_size = 2; data_wdata = 32'h12345678;
    #1;
    wait_any_gnt(k, gi, gd);
    @(negedge clk);
    data_req = 0;
    #1;
    n_chk++;
    if ({ctrl_start, ctrl_sel, ctrl_addr, ctrl_we, ctrl_size,
         ctrl_wdata} !== {1'b1, 2'd2, 24'h000004, 1'b1, 2'd2,
                          32'h12345678}) begin
      n_fail++;
      $display("FAIL wr_issue: got %b %0d %h %b %0d %h",
               ctrl_start, ctrl_sel, ctrl_addr, ctrl_we,
               ctrl_size, ctrl_wdata);
    end
    run_ctrl(2, '0, 0, irv, drv, idn, ddn, rs);
    data_we = 0;
    n_chk++;
    if ({idn, ddn} !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_done: got %b want 01", {idn, ddn});
    end
  endtask

  task automatic test_flash_write();
    int k;
    bit gi, gd, seen;
    @(negedge clk);
    data_req = 1; data_addr = 25'h0000040; data_we = 1;
    data_size = 2; data_wdata = 32'hCAFEF00D;
    #1;
    wait_any_gnt(k, gi, gd);
    n_chk++;
    if ({data_gnt, data_err, instr_gnt} !== 3'b110) begin
      n_fail++;
      $display("FAIL fw_gnt_err: got %b want 110",
               {data_gnt, data_err, instr_gnt});
    end
    seen = 0;
    @(negedge clk);
    data_req = 0; data_we = 0;
    #1;
    repeat (6) begin
      if (ctrl_start || ctrl_sel != 0 || data_err) seen = 1;
      @(negedge clk); #1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL fw_no_start: got %b want 0", seen);
    end
  endtask

  task automatic test_random();
    int k;
    bit gi, gd, irv, drv, idn, ddn, use_i, err, we;
    logic [31:0] rs, rd, wd;
    int unsigned a;
    logic [1:0] sz;
    for (int n = 0; n < 16; n++) begin
      use_i = ($urandom_range(0, 3) == 0);
      a = use_i ? $urandom_range(0, (1 << 24) - 1)
                : $urandom_range(0, (1 << 25) - 1);
      we = use_i ? 1'b0 : 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      wd = $urandom;
      rd = $urandom;
      err = !use_i && we && (a / (1 << 23) < 2);
      @(negedge clk);
      if (use_i) begin
        instr_req = 1; instr_addr = 24'(a);
      end else begin
        data_req = 1; data_addr = 25'(a); data_we = we;
        data_size = sz; data_wdata = wd;
      end
      #1;
      wait_any_gnt(k, gi, gd);
      n_chk++;
      if ({gi, gd, data_err} !== {use_i, !use_i, err}) begin
        n_fail++;
        $display("FAIL rnd_gnt_%0d: got %b want %b", n,
                 {gi, gd, data_err}, {use_i, !use_i, err});
      end
      @(negedge clk);
      instr_req = 0; data_req = 0;
      #1;
      if (err) begin
        n_chk++;
        if (ctrl_start !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_fw_%0d: got start %b want 0",
                   n, ctrl_start);
        end
        data_we = 0;
      end else begin
        n_chk++;
        if ({ctrl_start, ctrl_sel, ctrl_addr, ctrl_we} !==
            {1'b1, m_sel(a), m_addr(a), we} ||
            (!use_i && {ctrl_size, ctrl_wdata} !== {sz, wd})) begin
          n_fail++;
          $display("FAIL rnd_issue_%0d: got %b %0d %h %b %0d %h",
                   n, ctrl_start, ctrl_sel, ctrl_addr, ctrl_we,
                   ctrl_size, ctrl_wdata);
        end
        run_ctrl($urandom_range(0, 3), rd, !we,
                 irv, drv, idn, ddn, rs);
        data_we = 0;
        n_chk++;
        if ({idn, ddn} !== {use_i, !use_i} ||
            (!we && ({irv, drv, rs} !== {use_i, !use_i, rd})))
        begin
          n_fail++;
          $display("FAIL rnd_serve_%0d: got %b %h want rd %h",
                   n, {irv, drv, idn, ddn}, rs, rd);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    bit gi, gd, irv, drv, idn, ddn;
    logic [31:0] rs;
    logic [101:0] v;
    @(negedge clk);
    data_req = 1; data_addr = 25'h1000020; data_we = 0;
    data_size = 1;
    #1;
    wait_any_gnt(k, gi, gd);
    @(negedge clk); data_req = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); rst = 1; #1;
    @(negedge clk);
    ctrl_rvalid = 1; ctrl_done = 1; ctrl_rdata = '0;
    #1;
    v = all_outs();
    n_chk++;
    if (v !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outs: got %h want 0", v);
    end
    @(negedge clk);
    rst = 0; ctrl_rvalid = 0; ctrl_done = 0;
    #1;
    @(negedge clk);
    instr_req = 1; instr_addr = 24'h00ABCD;
    #1;
    n_chk++;
    if (instr_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_regnt: got %b want 1", instr_gnt);
    end
    @(negedge clk); instr_req = 0; #1;
    run_ctrl(0, 32'h600DCAFE, 1, irv, drv, idn, ddn, rs);
    n_chk++;
    if ({irv, idn, rs} !== {2'b11, 32'h600DCAFE}) begin
      n_fail++;
      $display("FAIL rst_mid_serve: got %b %h want 11 600dcafe",
               {irv, idn}, rs);
    end
  endtask

`ifdef QSPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k, c;
    bit gi, gd, irv, drv, idn, ddn;
    logic [31:0] rs;
    @(negedge clk);
    data_req = 1; data_addr = 25'h1C00008; data_we = 0;
    data_size = 2;
    #1;
    wait_any_gnt(k, gi, gd);
    @(negedge clk); data_req = 0; #1;
    c = 0;
    do begin
      @(negedge clk); #1;
      c++;
    end while (!ctrl_abort && c < 1100);
    n_chk++;
    if (c != TO || {data_done, data_err, instr_done} !== 3'b110)
    begin
      n_fail++;
      $display("FAIL to_abort: got c=%0d %b want c=%0d 110", c,
               {data_done, data_err, instr_done}, TO);
    end
    @(negedge clk);
    instr_req = 1; instr_addr = 24'h000040;
    #1;
    wait_any_gnt(k, gi, gd);
    n_chk++;
    if ({gi, gd} !== 2'b10) begin
      n_fail++;
      $display("FAIL to_resume_gnt: got %b want 10", {gi, gd});
    end
    @(negedge clk); instr_req = 0; #1;
    run_ctrl(1, 32'h13579BDF, 1, irv, drv, idn, ddn, rs);
    n_chk++;
    if ({irv, idn, ctrl_abort, rs} !== {3'b110, 32'h13579BDF}) begin
      n_fail++;
      $display("FAIL to_resume_serve: got %b %h",
               {irv, idn, ctrl_abort}, rs);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_instr_only();
    test_simultaneous();
    test_starvation();
    test_write_ram();
    test_flash_write();
    test_random();
    test_reset_mid();
`ifdef QSPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
